am_scan_decoder: RTL and testbench
==================================

# am_scan_decoder

Parametrised, registered 1-of-2^W decoder with address register and auto-scan sequencer: the clocked successor of the 2-to-4 decoders in the 74LS model library. It drives active-low select strobes (register files, microcode banks, peripheral chip selects) in bitslice test systems. The address register loads, holds, or steps through all outputs in wrap-around or one-shot order, so a strobe pattern needs no external counter.

## Interface
Parameters:
- WIDTH, 2, number of select bits; outputs N = 2**WIDTH (legal 1..6)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset: one clock, synchronous, active-high
- g_  in  1  active-low output enable; masks outputs only, never stops counting
- le_  in  1  active-low load enable for sel
- mode  in  2  00 LOAD, 01 HOLD, 10 SCANW (wrap), 11 SCAN1 (one-shot)
- sel  in  WIDTH  address to load
- y  out  N  active-low decoded outputs, registered
- cur  out  WIDTH  current address register value
- tc  out  1  registered terminal count: cur == N-1
- busy  out  1  SCAN1 still stepping (cur != N-1)

## Operation
- Internal state: address register `a` (WIDTH bits). Outputs derive from next value `a_n`, all updated on the same edge.
- `a_n` selection, first match wins:
  - rst: 0
  - le_=0 (any mode): sel
  - mode LOAD: sel (transparent load every cycle)
  - mode HOLD: a
  - mode SCANW: (a+1) mod N; N-1 wraps to 0
  - mode SCAN1: a+1 if a != N-1, else a (saturates)
- Register updates on edge: a <= a_n; cur <= a_n; y <= g_ ? all ones : ~(1 << a_n); tc <= (a_n == N-1); busy <= (mode==SCAN1) & (a_n != N-1).
- Exactly one y bit low when g_=0; none when g_=1. Never more than one low.
- Mode changes take effect on the next edge; no state apart from `a` is kept across mode changes.
- Increment is modulo 2**WIDTH; no carry out other than tc.

## Timing
- Reset values (after the rst edge): a=0, cur=0, y=all ones, tc=0 (WIDTH>=1), busy=0.
- rst dominates all inputs, including le_=0 and g_=0, during the same edge.
- Latency: sel/le_/g_/mode sampled at edge k appear on y/cur/tc/busy immediately after edge k (one register stage, no combinational path input->output).
- le_=0 with SCANW/SCAN1: the loaded value appears at edge k. Stepping resumes from it at edge k+1 if le_=1.
- SCAN1 from 0 with WIDTH=2: cur 1,2,3 on edges 1..3; busy drops and tc rises at edge 3. cur stays 3 afterwards.
- SCANW: tc high for exactly one cycle per wrap period of N cycles.
- g_ toggling mid-scan: y masked the same edge, cur keeps counting, and y resumes at the correct position.
- rst mid-scan: next cycle cur=0, y all ones, busy=0. Scanning continues from 0 on following edges if the mode is still a scan mode.

## Structure
- Package `am_scan_decoder_pkg`: mode localparams MODE_LOAD=2'b00, MODE_HOLD=2'b01, MODE_SCANW=2'b10, MODE_SCAN1=2'b11.
- Sub-module `am_onehot_dec` (combinational, parameter WIDTH): addr + g_ -> N-bit active-low one-hot. Instantiated on `a_n`, output registered in the top.
- Top: next-state mux, address/status registers.

## Test plan
- Reset: rst=1 with g_=0, le_=0, sel=3 -> after edge y=1111, cur=0, tc=0, busy=0.
- LOAD decode (W=2): g_=0, mode=00, sel=0..3 on successive edges -> y=1110,1101,1011,0111; tc only with sel=3. g_=1 -> y=1111.
- HOLD/load priority: mode=01, le_=0 sel=2, then le_=1 sel=0 for 3 edges -> cur stays 2, y=1011.
- SCANW wrap (W=3): load 6, then le_=1 -> cur 7,0,1. tc high only the cycle cur=7. y=01111111 then 11111110.
- SCAN1 saturate (W=2) from 0 -> cur 1,2,3,3; busy 1,1,0,0. Mid-scan le_=0 sel=1 restarts at 1 with busy=1.
- Masks and reset mid-scan: SCANW with g_=1 for 2 edges -> y=1111, cur still advances. rst mid-scan -> cur=0, y=1111 next cycle.

Source files
------------

// File: rtl/am_scan_decoder_pkg.sv
// Shared definitions for the scanning select decoder: mode encodings.
package am_scan_decoder_pkg;

  localparam logic [1:0] MODE_LOAD  = 2'b00;  // transparent load of sel every cycle
  localparam logic [1:0] MODE_HOLD  = 2'b01;  // keep current address
  localparam logic [1:0] MODE_SCANW = 2'b10;  // step, wrap N-1 -> 0
  localparam logic [1:0] MODE_SCAN1 = 2'b11;  // step once through, stop at N-1

endpackage

// File: rtl/am_onehot_dec.sv
// Combinational 1-of-2^WIDTH decoder with active-low outputs and an
// active-low enable that forces every output high.
module am_onehot_dec #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0]      addr,
  input  logic                  g_,
  output logic [(2**WIDTH)-1:0] y
);

  genvar gi;
  generate
    for (gi = 0; gi < 2**WIDTH; gi++) begin : g_dec
      // Output gi is pulled low only when enabled and addressed.
      assign y[gi] = g_ | (addr != WIDTH'(gi));
    end
  endgenerate

endmodule

// File: rtl/am_scan_decoder.sv
// Registered select-strobe decoder with an address register that can load,
// hold, or auto-scan (wrap-around or one-shot). All outputs come from the
// next address so they change together on a single edge.
module am_scan_decoder
  import am_scan_decoder_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  g_,
  input  logic                  le_,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      sel,
  output logic [(2**WIDTH)-1:0] y,
  output logic [WIDTH-1:0]      cur,
  output logic                  tc,
  output logic                  busy
);

  localparam int N = 2**WIDTH;
  localparam logic [WIDTH-1:0] LAST = {WIDTH{1'b1}};

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] a_next;
  logic [N-1:0]     y_next;
  logic [N-1:0]     y_reg;
  logic             tc_reg;
  logic             busy_reg;

  // Next address: an asserted load enable overrides whatever mode is selected.
  always_comb begin
    a_next = a_reg;
    if (!le_) begin
      a_next = sel;
    end else begin
      case (mode)
        MODE_LOAD:  a_next = sel;
        MODE_HOLD:  a_next = a_reg;
        MODE_SCANW: a_next = a_reg + WIDTH'(1);
        MODE_SCAN1: a_next = (a_reg == LAST) ? a_reg : a_reg + WIDTH'(1);
        default:    a_next = a_reg;
      endcase
    end
  end

  // Strobes are decoded from the next address so y lines up with cur.
  am_onehot_dec #(
    .WIDTH (WIDTH)
  ) u_dec (
    .addr (a_next),
    .g_   (g_),
    .y    (y_next)
  );

  // Address and status registers; reset beats load and enable on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      y_reg    <= '1;
      tc_reg   <= 1'b0;
      busy_reg <= 1'b0;
    end else begin
      a_reg    <= a_next;
      y_reg    <= y_next;
      tc_reg   <= (a_next == LAST);
      busy_reg <= (mode == MODE_SCAN1) && (a_next != LAST);
    end
  end

  // cur is the address register itself; it never needs a separate copy.
  assign cur  = a_reg;
  assign y    = y_reg;
  assign tc   = tc_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_am_scan_decoder.sv
// Bench for am_scan_decoder: a WIDTH=2 and a WIDTH=3 instance share the
// same stimulus. Both are tracked by an arithmetic reference model on every
// edge; a vector table and hand sequences add fixed expected values.
module tb_am_scan_decoder;

  logic       clk;
  logic       rst;
  logic       g_;
  logic       le_;
  logic [1:0] mode;
  logic [2:0] sel3;
  logic [1:0] sel2;

  logic [3:0] y2;
  logic [1:0] cur2;
  logic       tc2, busy2;
  logic [7:0] y3;
  logic [2:0] cur3;
  logic       tc3, busy3;

  int vectors;
  int miscompares;

  // Reference model state: plain integer addresses.
  int m2, m3;
  int e_y2, e_y3, e_tc2, e_tc3, e_busy2, e_busy3;

  assign sel2 = sel3[1:0];

  am_scan_decoder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .g_(g_), .le_(le_), .mode(mode), .sel(sel2),
    .y(y2), .cur(cur2), .tc(tc2), .busy(busy2)
  );

  am_scan_decoder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .g_(g_), .le_(le_), .mode(mode), .sel(sel3),
    .y(y3), .cur(cur3), .tc(tc3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rst; int g; int le; int mode; int sel;
    int y; int cur; int tc; int busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int r, int g, int l, int md, int s,
                              int y, int c, int t, int b);
    vec_t v;
    v.rst = r; v.g = g; v.le = l; v.mode = md; v.sel = s;
    v.y = y; v.cur = c; v.tc = t; v.busy = b;
    return v;
  endfunction

  // Next address from the behavioural rules, for an N-output decoder.
  function automatic int model_next(int a, int n, int r, int l, int md, int s);
    if (r != 0) return 0;
    if (l == 0) return s % n;
    case (md)
      0: return s % n;
      1: return a;
      2: return (a + 1) % n;
      default: return (a == n - 1) ? a : a + 1;
    endcase
  endfunction

  function automatic int model_y(int a, int n, int r, int g);
    int all_ones;
    all_ones = (1 << n) - 1;
    if (r != 0 || g != 0) return all_ones;
    return all_ones & ~(1 << a);
  endfunction

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge: advance the model with the sampled inputs, then compare
  // both instances against it just after the edge.
  task automatic step();
    int r, g, l, md, s;
    @(posedge clk);
    r = int'(rst); g = int'(g_); l = int'(le_); md = int'(mode); s = int'(sel3);
    m2 = model_next(m2, 4, r, l, md, s);
    m3 = model_next(m3, 8, r, l, md, s);
    e_y2 = model_y(m2, 4, r, g);
    e_y3 = model_y(m3, 8, r, g);
    e_tc2 = (r == 0 && m2 == 3) ? 1 : 0;
    e_tc3 = (r == 0 && m3 == 7) ? 1 : 0;
    e_busy2 = (r == 0 && md == 3 && m2 != 3) ? 1 : 0;
    e_busy3 = (r == 0 && md == 3 && m3 != 7) ? 1 : 0;
    #1;
    chk("model_y2",    int'(y2),    e_y2);
    chk("model_cur2",  int'(cur2),  m2);
    chk("model_tc2",   int'(tc2),   e_tc2);
    chk("model_busy2", int'(busy2), e_busy2);
    chk("model_y3",    int'(y3),    e_y3);
    chk("model_cur3",  int'(cur3),  m3);
    chk("model_tc3",   int'(tc3),   e_tc3);
    chk("model_busy3", int'(busy3), e_busy3);
  endtask

  task automatic drive(int r, int g, int l, int md, int s);
    rst  = r[0];
    g_   = g[0];
    le_  = l[0];
    mode = md[1:0];
    sel3 = s[2:0];
  endtask

  initial begin
    int tc_count;
    vectors = 0;
    miscompares = 0;
    m2 = 0;
    m3 = 0;
    drive(1, 0, 0, 0, 3);

    // Fixed WIDTH=2 vectors: reset, decode, hold priority, one-shot scan,
    // restart, reset mid-scan, masking mid-scan.
    //            rst g le md sel   y        cur tc busy
    tbl.push_back(mk(1, 0, 0, 0, 3, 4'b1111, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 4'b1110, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 4'b1101, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2, 4'b1011, 2, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 3, 4'b0111, 3, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 3, 4'b1111, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2, 4'b1011, 2, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 4'b1011, 2, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 4'b1011, 2, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 4'b1011, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 3, 0, 4'b1110, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 3, 0, 4'b1101, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 3, 0, 4'b1011, 2, 0, 1));
    tbl.push_back(mk(0, 0, 1, 3, 0, 4'b0111, 3, 1, 0));
    tbl.push_back(mk(0, 0, 1, 3, 0, 4'b0111, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 3, 1, 4'b1101, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 3, 1, 4'b1011, 2, 0, 1));
    tbl.push_back(mk(0, 0, 1, 2, 1, 4'b0111, 3, 1, 0));
    tbl.push_back(mk(1, 0, 1, 2, 1, 4'b1111, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 1, 4'b1101, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 2, 1, 4'b1111, 2, 0, 0));
    tbl.push_back(mk(0, 1, 1, 2, 1, 4'b1111, 3, 1, 0));
    tbl.push_back(mk(0, 0, 1, 2, 1, 4'b1110, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].g, tbl[i].le, tbl[i].mode, tbl[i].sel);
      step();
      chk($sformatf("tbl%0d_y", i),    int'(y2),    tbl[i].y);
      chk($sformatf("tbl%0d_cur", i),  int'(cur2),  tbl[i].cur);
      chk($sformatf("tbl%0d_tc", i),   int'(tc2),   tbl[i].tc);
      chk($sformatf("tbl%0d_busy", i), int'(busy2), tbl[i].busy);
      $display("vec %0d: rst=%0d g_=%0d le_=%0d mode=%0d sel=%0d -> y=%b cur=%0d tc=%0b busy=%0b",
               i, tbl[i].rst, tbl[i].g, tbl[i].le, tbl[i].mode, tbl[i].sel,
               y2, cur2, tc2, busy2);
    end

    // WIDTH=3 wrap: load 6, then step through 7, 0, 1.
    drive(0, 0, 0, 2, 6);
    step();
    chk("w3_load_cur", int'(cur3), 6);
    chk("w3_load_y",   int'(y3),   8'hBF);
    chk("w3_load_tc",  int'(tc3),  0);
    drive(0, 0, 1, 2, 6);
    step();
    chk("w3_cur7", int'(cur3), 7);
    chk("w3_y7",   int'(y3),   8'h7F);
    chk("w3_tc7",  int'(tc3),  1);
    step();
    chk("w3_cur0", int'(cur3), 0);
    chk("w3_y0",   int'(y3),   8'hFE);
    chk("w3_tc0",  int'(tc3),  0);
    step();
    chk("w3_cur1", int'(cur3), 1);
    chk("w3_tc1",  int'(tc3),  0);

    // tc pulses exactly once per 8-cycle wrap period.
    tc_count = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (tc3) tc_count++;
    end
    chk("w3_tc_per_period", tc_count, 2);
    $display("wrap: %0d tc pulses over 16 cycles", tc_count);

    // Randomized stimulus against the model only.
    for (int k = 0; k < 600; k++) begin
      drive(($urandom_range(0, 31) == 0) ? 1 : 0,
            ($urandom_range(0, 3) == 0) ? 1 : 0,
            ($urandom_range(0, 3) == 0) ? 0 : 1,
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)));
      step();
    end
    $display("random: 600 cycles applied");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
